// File: rtl/serial_bus_sequencer_if.sv
// ============================================================================
// Module   : serial_bus_sequencer_if
// Purpose  : Requester, combiner and serial-link signals of the bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_bus_sequencer_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*4-1:0]      req_len;
    logic                    buff_full;
    logic                    bus_held;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    busy;
    logic                    scl;
    logic                    sda;

    modport master (
        input  req, req_data, req_len, buff_full, bus_held,
        output gnt, done, busy, scl, sda
    );

    modport slave (
        output req, req_data, req_len, buff_full, bus_held,
        input  gnt, done, busy, scl, sda
    );
endinterface

`default_nettype wire

// File: rtl/serial_bus_sequencer.sv
// ============================================================================
// Module   : serial_bus_sequencer
// Purpose  : Round-robin bus master framing requester words onto scl/sda.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bus_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8,
    parameter int N_REQ   = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    serial_bus_sequencer_if.master bus
);

    localparam int c_CNT_W = $clog2(CLK_DIV);
    localparam int c_LEN_W = $clog2(DATA_W + 1);
    localparam int c_PTR_W = $clog2(N_REQ);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(N_REQ - 1);
    localparam logic [c_PTR_W:0]   c_N_REQ_X  = (c_PTR_W + 1)'(N_REQ);
    localparam logic [c_LEN_W-1:0] c_LEN_ONE  = c_LEN_W'(1);
    localparam logic [c_LEN_W-1:0] c_LEN_MAX  = c_LEN_W'(DATA_W);
    localparam logic [N_REQ-1:0]   c_GNT_ONE  = N_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_BIT_LO    = 3'd2,
        S_BIT_HI    = 3'd3,
        S_STOP_LO   = 3'd4,
        S_STOP_HI   = 3'd5,
        S_STOP_IDLE = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [c_PTR_W-1:0]   ptr_q,   ptr_d;
    logic [DATA_W-1:0]    sh_q,    sh_d;
    logic [c_LEN_W-1:0]   rem_q,   rem_d;
    logic [N_REQ-1:0]     gnt_q,   gnt_d;
    logic [N_REQ-1:0]     done_q,  done_d;
    logic                 busy_q,  busy_d;
    logic                 scl_q,   scl_d;
    logic                 sda_q,   sda_d;

    logic                 w_found;
    logic [c_PTR_W-1:0]   w_winner;
    logic [c_PTR_W:0]     w_idx;
    logic [DATA_W-1:0]    w_sel_data;
    logic [3:0]           w_sel_len;
    logic [c_LEN_W-1:0]   w_len;
    logic                 w_stall;
    logic                 w_tick;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = ptr_q;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, ptr_q} + (c_PTR_W + 1)'(k);
            if (w_idx >= c_N_REQ_X) begin
                w_idx = w_idx - c_N_REQ_X;
            end
            if (!w_found && bus.req[w_idx[c_PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == c_PTR_W'(i)) begin
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
                w_sel_len  = bus.req_len[i*4 +: 4];
            end
        end
        w_len = (int'(w_sel_len) > DATA_W) ? c_LEN_MAX : c_LEN_W'(w_sel_len);
    end

    // Backpressure freezes the divider only in the data-low phase.
    assign w_stall = (state_q == S_BIT_LO) && bus.buff_full;
    assign w_tick  = busy_q && !w_stall && (cnt_q == c_CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;

        if (busy_q && !w_stall) begin
            cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_found && !bus.bus_held) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    gnt_d   = c_GNT_ONE << w_winner;
                    busy_d  = 1'b1;
                    sh_d    = w_sel_data;
                    rem_d   = w_len;
                    ptr_d   = (w_winner == c_PTR_LAST) ? '0 : w_winner + 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    state_d = (rem_q == '0) ? S_STOP_LO : S_BIT_LO;
                end
            end
            S_BIT_LO: begin
                if (w_tick) begin
                    state_d = S_BIT_HI;
                end
            end
            S_BIT_HI: begin
                if (w_tick) begin
                    sh_d    = sh_q << 1;
                    rem_d   = rem_q - c_LEN_ONE;
                    state_d = (rem_q == c_LEN_ONE) ? S_STOP_LO : S_BIT_LO;
                end
            end
            S_STOP_LO: begin
                if (w_tick) begin
                    state_d = S_STOP_HI;
                end
            end
            S_STOP_HI: begin
                if (w_tick) begin
                    state_d = S_STOP_IDLE;
                end
            end
            S_STOP_IDLE: begin
                if (w_tick) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Line levels are decoded from the next state so scl/sda leave a flop.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            S_START: begin
                sda_d = 1'b0;
            end
            S_BIT_LO: begin
                scl_d = 1'b0;
                sda_d = sh_d[DATA_W-1];
            end
            S_BIT_HI: begin
                sda_d = sh_d[DATA_W-1];
            end
            S_STOP_LO: begin
                scl_d = 1'b0;
                sda_d = 1'b0;
            end
            S_STOP_HI: begin
                sda_d = 1'b0;
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.scl  = scl_q;
    assign bus.sda  = sda_q;

endmodule

`default_nettype wire
